lsu_load_store: RTL and testbench

- Multi-cycle load/store unit between the execute stage and the data-memory bus.
- Consumes the effective address (ALU result) and the store data (register file read port 2).
- Produces load results that drive the register file write port (write/wa/wd).
- Handles RV32I byte/halfword/word lane steering, load sign/zero extension, and a req/gnt/rvalid memory handshake.

---
 rtl/lsu_load_store.sv | 192 +++++++++++++++++++
 tb/tb_lsu_load_store.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_load_store.sv
// lsu_load_store: multi-cycle RV32I load/store unit between execute and the data bus.
// Steers byte/halfword/word lanes for stores, extends load data for the register
// file, and runs a req/gnt/rvalid handshake (IDLE -> REQ -> WAIT -> WB -> RESP).
// Optional feature macro: LSU_MISALIGN_CHECK_EN rejects misaligned H/W accesses.
module lsu_load_store #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          is_store,
    input  logic [2:0]    funct3,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   store_data,
    input  logic [4:0]    rd_addr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wstrb,
    output logic [31:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          rf_write,
    output logic [4:0]    rf_wa,
    output logic [31:0]   rf_wd
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] WB   = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          store_q, store_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    off_q, off_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [4:0]    rd_q, rd_d;
    logic          err_q, err_d;
    logic [31:0]   wd_q, wd_d;

    logic          reject;
    logic          misaligned;
    logic [3:0]    st_wstrb;
    logic [31:0]   st_wdata;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;

    // Classify the incoming request: unsupported width codes (and, optionally, misalignment) are rejected
    always_comb begin
        misaligned = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if (funct3[1:0] == 2'b01)
            misaligned = addr[0];
        else if (funct3[1:0] == 2'b10)
            misaligned = (addr[1:0] != 2'b00);
`endif
        if (is_store)
            reject = (funct3 >= 3'b011) || misaligned;
        else
            reject = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) || misaligned;
    end

    // Store lane steering: replicate data across lanes and enable only the addressed bytes
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << addr[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension of the returned word
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Sequencing: capture the request in IDLE, then walk the bus handshake to writeback and response
    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        err_d    = err_q;
        wd_d     = wd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    store_d  = is_store;
                    funct3_d = funct3;
                    off_d    = addr[1:0];
                    addr_d   = {addr[AW-1:2], 2'b00};
                    wstrb_d  = (is_store && !reject) ? st_wstrb : 4'b0000;
                    wdata_d  = is_store ? st_wdata : 32'd0;
                    rd_d     = rd_addr;
                    err_d    = reject;
                    state_d  = reject ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt)
                    state_d = store_q ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    wd_d    = ld_ext;
                    state_d = WB;
                end
            end
            WB:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            addr_q   <= '0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
            rd_q     <= 5'd0;
            err_q    <= 1'b0;
            wd_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    // Outputs decoded from the current state and the captured request
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == RESP);
        err       = (state_q == RESP) && err_q;
        mem_req   = (state_q == REQ);
        mem_we    = (state_q == REQ) && store_q;
        mem_addr  = addr_q;
        mem_wstrb = wstrb_q;
        mem_wdata = wdata_q;
        rf_write  = (state_q == WB) && (rd_q != 5'd0);
        rf_wa     = (state_q == WB) ? rd_q : 5'd0;
        rf_wd     = wd_q;
    end

endmodule

// File: tb/tb_lsu_load_store.sv
// tb_lsu_load_store: directed transactions against a transaction-level model of lsu_load_store.
// Each transaction's expected bus fields, writeback data, error flag and completion cycle are
// computed from the access rules with plain arithmetic; a negedge monitor compares every cycle.
module tb_lsu_load_store;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          is_store;
    logic [2:0]    funct3;
    logic [AW-1:0] addr;
    logic [31:0]   store_data;
    logic [4:0]    rd_addr;
    logic          busy, done, err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_wdata;
    logic          mem_gnt, mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          rf_write;
    logic [4:0]    rf_wa;
    logic [31:0]   rf_wd;

    always #5 clk = ~clk;

    lsu_load_store #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .rd_addr(rd_addr),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_write(rf_write), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected transaction, produced by the model
    logic        exp_err, exp_store;
    logic [31:0] exp_addr, exp_wdata, exp_wd;
    logic [3:0]  exp_wstrb;
    logic [4:0]  exp_rd;
    int          exp_wb_cnt, exp_done_rel;

    // Observations gathered by the monitor
    bit          mon_on = 0;
    bit          finished;
    int          t0, mon_rel;
    int          req_cnt, wb_cnt, done_cnt, wb_rel, done_rel;
    logic [31:0] last_addr, last_wdata, last_wd;
    logic [3:0]  last_wstrb;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Transaction-level model: what the bus and register file must see for one access
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rdat, input logic [4:0] rd,
                         input int gd, input int rvd);
        int          off;
        logic [31:0] b, h, sb, shw;
        off = int'(a[1:0]);
        b   = (rdat >> (8 * off)) & 32'hFF;
        h   = (rdat >> (16 * (off / 2))) & 32'hFFFF;
        sb  = sd & 32'hFF;
        shw = sd & 32'hFFFF;
        exp_store = st;
        exp_rd    = rd;
        if (st) exp_err = (f3 >= 3'd3);
        else    exp_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef LSU_MISALIGN_CHECK_EN
        if (!exp_err && (f3 % 4 == 1) && (off % 2 == 1)) exp_err = 1'b1;
        if (!exp_err && (f3 % 4 == 2) && (off != 0))     exp_err = 1'b1;
`endif
        exp_addr  = a - off;
        exp_wstrb = 4'h0;
        exp_wdata = 32'h0;
        exp_wd    = 32'h0;
        if (st) begin
            if (f3 == 3'd0)      begin exp_wstrb = 4'(1 << off); exp_wdata = sb * 32'h01010101; end
            else if (f3 == 3'd1) begin exp_wstrb = (off >= 2) ? 4'hC : 4'h3; exp_wdata = shw * 32'h00010001; end
            else                 begin exp_wstrb = 4'hF; exp_wdata = sd; end
        end else begin
            case (f3)
                3'd0:    exp_wd = (b >= 128)   ? b - 32'd256   : b;
                3'd1:    exp_wd = (h >= 32768) ? h - 32'd65536 : h;
                3'd4:    exp_wd = b;
                3'd5:    exp_wd = h;
                default: exp_wd = rdat;
            endcase
        end
        exp_wb_cnt   = (!st && !exp_err && rd != 0) ? 1 : 0;
        exp_done_rel = exp_err ? 1 : (st ? 2 + gd : 4 + gd + rvd);
    endtask

    // Per-cycle compare of DUT outputs against the current expected transaction
    always @(negedge clk) begin
        if (mon_on && !finished) begin
            mon_rel = cyc - t0;
            checkOutput("busy", busy, (mon_rel >= 1));
            if (mem_req) begin
                req_cnt++;
                if (exp_err) checkOutput("req_on_reject", mem_req, 0);
                else begin
                    checkOutput("mem_addr", mem_addr, exp_addr);
                    checkOutput("mem_we", mem_we, exp_store);
                    checkOutput("mem_wstrb", mem_wstrb, exp_wstrb);
                    if (exp_store) checkOutput("mem_wdata", mem_wdata, exp_wdata);
                end
                last_addr  = mem_addr;
                last_wstrb = mem_wstrb;
                last_wdata = mem_wdata;
            end
            if (rf_write) begin
                wb_cnt++;
                wb_rel  = mon_rel;
                last_wd = rf_wd;
                checkOutput("rf_wa", rf_wa, exp_rd);
                checkOutput("rf_wd", rf_wd, exp_wd);
            end
            if (err && !done) checkOutput("err_without_done", err, 0);
            if (done) begin
                done_cnt++;
                done_rel = mon_rel;
                checkOutput("err", err, exp_err);
                if (!exp_store && !exp_err && exp_rd != 0) checkOutput("rf_wd_hold", rf_wd, exp_wd);
                finished = 1;
            end
        end
    end

    // Issue one access and play the memory side with the given grant / rvalid delays
    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdat,
                                 input int gd, input int rvd, input bit restart);
        int req_seen = 0;
        int gnt_at   = -1;
        model(st, f3, a, sd, rdat, rd, gd, rvd);
        req_cnt = 0; wb_cnt = 0; done_cnt = 0; wb_rel = -1; done_rel = -1; finished = 0;
        @(posedge clk); #1;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd_addr = rd;
        t0 = cyc;
        mon_on = 1;
        for (int k = 1; k <= 40 && !finished; k++) begin
            @(posedge clk); #1;
            start      = restart && (k == 2);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = ~rdat;
            if (mem_req) begin
                req_seen++;
                if (req_seen > gd) begin
                    mem_gnt = 1'b1;
                    gnt_at  = k;
                end
            end else if (gnt_at >= 0 && !st && k == gnt_at + 1 + rvd) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdat;
            end
        end
        if (!finished) checkOutput("timeout", finished, 1);
        mon_on = 0;
        checkOutput("done_count", done_cnt, 1);
        checkOutput("wb_count", wb_cnt, exp_wb_cnt);
        checkOutput("done_cycle", done_rel, exp_done_rel);
        if (exp_wb_cnt == 1) checkOutput("wb_cycle", wb_rel, exp_done_rel - 1);
        checkOutput("bus_access", (req_cnt != 0), !exp_err);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_done", done, 0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_mem_req"}, mem_req, 0);
        checkOutput({tag, "_mem_we"}, mem_we, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_wstrb"}, mem_wstrb, 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_rf_write"}, rf_write, 0);
        checkOutput({tag, "_rf_wa"}, rf_wa, 0);
        checkOutput({tag, "_rf_wd"}, rf_wd, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = '0;
        store_data = 32'd0; rd_addr = 5'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        #2;
        checkAllZero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Loads: byte/half lanes with sign and zero extension at minimum latency
        applyStimulus(1'b0, 3'b000, 32'h1003, 32'h0, 5'd5, 32'h80223344, 0, 0, 0);
        checkOutput("t1_lb_wd", last_wd, 32'hFFFFFF80);
        checkOutput("t1_lb_wb_cycle", wb_rel, 3);
        checkOutput("t1_lb_done_cycle", done_rel, 4);
        applyStimulus(1'b0, 3'b100, 32'h1003, 32'h0, 5'd5, 32'h80223344, 0, 0, 0);
        checkOutput("t1_lbu_wd", last_wd, 32'h00000080);
        applyStimulus(1'b0, 3'b000, 32'h1001, 32'h0, 5'd6, 32'h80223344, 0, 0, 0);
        applyStimulus(1'b0, 3'b001, 32'h1002, 32'h0, 5'd7, 32'h80223344, 0, 0, 0);
        checkOutput("lh_wd", last_wd, 32'hFFFF8022);
        applyStimulus(1'b0, 3'b101, 32'h1000, 32'h0, 5'd8, 32'h8022B344, 1, 1, 0);
        checkOutput("lhu_wd", last_wd, 32'h0000B344);

        // Stores: lane strobes and replicated data
        applyStimulus(1'b1, 3'b000, 32'h2001, 32'h000000AB, 5'd0, 32'h0, 0, 0, 0);
        checkOutput("t2_sb_addr", last_addr, 32'h2000);
        checkOutput("t2_sb_wstrb", last_wstrb, 4'b0010);
        checkOutput("t2_sb_wdata", last_wdata, 32'hABABABAB);
        checkOutput("t2_sb_done_cycle", done_rel, 2);
        applyStimulus(1'b1, 3'b001, 32'h2002, 32'h00001234, 5'd0, 32'h0, 0, 0, 0);
        checkOutput("t2_sh_wstrb", last_wstrb, 4'b1100);
        checkOutput("t2_sh_wdata", last_wdata, 32'h12341234);
        applyStimulus(1'b1, 3'b010, 32'h2004, 32'hCAFEF00D, 5'd0, 32'h0, 2, 0, 0);

        // Stretched handshake with a start pulse while busy
        applyStimulus(1'b0, 3'b010, 32'h4008, 32'h0, 5'd9, 32'h13579BDF, 3, 2, 1);
        checkOutput("t3_done_cycle", done_rel, 9);
        checkOutput("t3_wd", last_wd, 32'h13579BDF);

        // Load to x0: bus access but no register write
        applyStimulus(1'b0, 3'b010, 32'h5000, 32'h0, 5'd0, 32'hDEADBEEF, 0, 0, 0);
        checkOutput("t4_bus_used", req_cnt, 1);
        checkOutput("t4_no_write", wb_cnt, 0);

        // Illegal width codes and misalignment
        applyStimulus(1'b0, 3'b011, 32'h1000, 32'h0, 5'd3, 32'h11111111, 0, 0, 0);
        checkOutput("t5_illegal_done_cycle", done_rel, 1);
        checkOutput("t5_illegal_no_req", req_cnt, 0);
        applyStimulus(1'b1, 3'b100, 32'h1000, 32'h55, 5'd0, 32'h0, 0, 0, 0);
        applyStimulus(1'b0, 3'b010, 32'h1002, 32'h0, 5'd4, 32'h2468ACE0, 0, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        checkOutput("t5_misalign_done_cycle", done_rel, 1);
        checkOutput("t5_misalign_no_req", req_cnt, 0);
`else
        checkOutput("t5_misalign_addr", last_addr, 32'h1000);
        checkOutput("t5_misalign_wd", last_wd, 32'h2468ACE0);
`endif
        applyStimulus(1'b0, 3'b001, 32'h1001, 32'h0, 5'd10, 32'h80223344, 0, 0, 0);

        // Reset during WAIT, then a stray rvalid after release
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h3000; rd_addr = 5'd7;
        @(posedge clk); #1;
        start = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        checkOutput("t6_wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkAllZero("t6_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("t6_no_write", rf_write, 0);
            checkOutput("t6_no_done", done, 0);
            checkOutput("t6_no_busy", busy, 0);
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 3'b100, 32'h3002, 32'h0, 5'd12, 32'h00F10000, 0, 0, 0);
        checkOutput("t6_after_wd", last_wd, 32'h000000F1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
